// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage MIPS core.
//
// Sits beside the ID stage. It detects load-use data hazards (EX, and
// optionally MEM), structural hazards on the multi-cycle divider, and
// external front-end holds. From these it drives the front-end write enables,
// the ID/EX bubble and the IF/ID flush. It also tracks divider occupancy and
// keeps a saturating count of stalled cycles.
//
// Parameters:
//   AW         register address width
//   LOAD_LAT   1: load result missing in EX only; 2: missing in EX and MEM
//   DIV_CYCLES divider occupancy in cycles after issue (>= 2)
//   CNT_W      stall counter width
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs, id_rt                  source fields of the ID instruction
//   id_use_rs, id_use_rt          ID instruction actually reads rs / rt
//   id_is_div, id_uses_hilo       ID is a divide/multiply, or touches HI/LO
//   id_redirect                   ID branch taken, or jump in ID
//   ex_rw, ex_mem_rd              EX destination register / EX is a load
//   mem_rw, mem_mem_rd            MEM destination register / MEM is a load
//   ext_stall                     external hold
//   pc_wr, if_id_wr               front-end write enables
//   id_ex_bubble                  load a NOP into ID/EX
//   if_id_flush                   discard the instruction fetched after a redirect
//   div_start                     one-cycle divider issue pulse
//   div_busy                      divider occupied (registered)
//   stall_cnt                     saturating stalled-cycle count (registered)
module hazard_ctrl #(
  parameter int AW         = 5,
  parameter int LOAD_LAT   = 1,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_div,
  input  logic             id_uses_hilo,
  input  logic             id_redirect,
  input  logic [AW-1:0]    ex_rw,
  input  logic             ex_mem_rd,
  input  logic [AW-1:0]    mem_rw,
  input  logic             mem_mem_rd,
  input  logic             ext_stall,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             div_start,
  output logic             div_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DCW = $clog2(DIV_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} div_state_t;

  div_state_t     state;
  logic [DCW-1:0] dcnt;

  logic ld_hz_ex;
  logic ld_hz_mem;
  logic div_hz;
  logic stall;

  // Register $0 is hard-wired to zero, so it can never carry a hazard.
  function automatic logic reg_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && (a != '0);
  endfunction

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign ld_hz_ex = ex_mem_rd &&
                    ((id_use_rs && reg_match(id_rs, ex_rw)) ||
                     (id_use_rt && reg_match(id_rt, ex_rw)));

  // With a single-cycle load shadow the MEM stage always forwards in time.
  assign ld_hz_mem = (LOAD_LAT >= 2) && mem_mem_rd &&
                     ((id_use_rs && reg_match(id_rs, mem_rw)) ||
                      (id_use_rt && reg_match(id_rt, mem_rw)));

  assign div_hz = div_busy && (id_is_div || id_uses_hilo);
  assign stall  = ld_hz_ex || ld_hz_mem || div_hz || ext_stall;

  // Hazard outputs are combinational; reset forces the free-running values.
  // A redirect under stall is dropped: the branch is still in ID and will
  // present it again once the stall clears.
  always_comb begin
    pc_wr        = 1'b1;
    if_id_wr     = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    div_start    = 1'b0;
    if (!rst) begin
      pc_wr        = !stall;
      if_id_wr     = !stall;
      id_ex_bubble = stall;
      if_id_flush  = id_redirect && !stall;
      div_start    = id_is_div && !stall;
    end
  end

  // Divider occupancy and stall counter. div_start can only fire in IDLE
  // because div_hz holds any divide back while BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dcnt      <= '0;
      div_busy  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_start) begin
            state    <= BUSY;
            dcnt     <= DCW'(DIV_CYCLES);
            div_busy <= 1'b1;
          end
        end
        BUSY: begin
          dcnt <= dcnt - DCW'(1);
          if (dcnt == DCW'(1)) begin
            state    <= IDLE;
            div_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          div_busy <= 1'b0;
        end
      endcase
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int DC = 4;
  localparam int CW = 3;
  localparam int CMAX = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] id_rs, id_rt, ex_rw, mem_rw;
  logic          id_use_rs, id_use_rt, id_is_div, id_uses_hilo, id_redirect;
  logic          ex_mem_rd, mem_mem_rd, ext_stall;

  logic          pc_wr1, ifid_wr1, bub1, fl1, ds1, db1;
  logic [CW-1:0] cnt1;
  logic          pc_wr2, ifid_wr2, bub2, fl2, ds2, db2;
  logic [CW-1:0] cnt2;

  hazard_ctrl #(.AW(AW), .LOAD_LAT(1), .DIV_CYCLES(DC), .CNT_W(CW)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_div(id_is_div),
    .id_uses_hilo(id_uses_hilo), .id_redirect(id_redirect),
    .ex_rw(ex_rw), .ex_mem_rd(ex_mem_rd), .mem_rw(mem_rw), .mem_mem_rd(mem_mem_rd),
    .ext_stall(ext_stall), .pc_wr(pc_wr1), .if_id_wr(ifid_wr1), .id_ex_bubble(bub1),
    .if_id_flush(fl1), .div_start(ds1), .div_busy(db1), .stall_cnt(cnt1));

  hazard_ctrl #(.AW(AW), .LOAD_LAT(2), .DIV_CYCLES(DC), .CNT_W(CW)) u2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_is_div(id_is_div),
    .id_uses_hilo(id_uses_hilo), .id_redirect(id_redirect),
    .ex_rw(ex_rw), .ex_mem_rd(ex_mem_rd), .mem_rw(mem_rw), .mem_mem_rd(mem_mem_rd),
    .ext_stall(ext_stall), .pc_wr(pc_wr2), .if_id_wr(ifid_wr2), .id_ex_bubble(bub2),
    .if_id_flush(fl2), .div_start(ds2), .div_busy(db2), .stall_cnt(cnt2));

  // Packed view: {pc_wr, if_id_wr, bubble, flush, div_start, div_busy, stall_cnt}
  logic [8:0] o1, o2;
  assign o1 = {pc_wr1, ifid_wr1, bub1, fl1, ds1, db1, cnt1};
  assign o2 = {pc_wr2, ifid_wr2, bub2, fl2, ds2, db2, cnt2};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: remaining divider cycles and stall total per instance
  // (index 0: load shadow of one stage, index 1: two stages).
  int m_busy[2] = '{0, 0};
  int m_cnt[2]  = '{0, 0};

  function automatic bit uses_reg(input int r);
    return (id_use_rs && int'(id_rs) == r) || (id_use_rt && int'(id_rt) == r);
  endfunction

  function automatic bit model_stall(input int k);
    bit ld_ex, ld_mem, dv;
    ld_ex  = ex_mem_rd && ex_rw != 0 && uses_reg(int'(ex_rw));
    ld_mem = (k == 1) && mem_mem_rd && mem_rw != 0 && uses_reg(int'(mem_rw));
    dv     = (m_busy[k] > 0) && (id_is_div || id_uses_hilo);
    return ld_ex || ld_mem || dv || ext_stall;
  endfunction

  function automatic logic [8:0] model_out(input int k);
    bit st;
    logic [2:0] c;
    st = model_stall(k);
    c  = 3'(m_cnt[k]);
    if (rst) return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_busy[k] > 0, c};
    return {!st, !st, st, id_redirect && !st, id_is_div && !st, m_busy[k] > 0, c};
  endfunction

  // Advance one clock, updating the model with the pre-edge inputs.
  task automatic tick();
    int nb[2];
    int nc[2];
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        nb[k] = 0;
        nc[k] = 0;
      end else begin
        bit st;
        st    = model_stall(k);
        nb[k] = (m_busy[k] > 0) ? m_busy[k] - 1 : ((id_is_div && !st) ? DC : 0);
        nc[k] = st ? ((m_cnt[k] >= CMAX) ? CMAX : m_cnt[k] + 1) : m_cnt[k];
      end
    end
    @(posedge clk);
    m_busy = nb;
    m_cnt  = nc;
    #1;
  endtask

  task automatic clr_inputs();
    id_rs = '0; id_rt = '0; ex_rw = '0; mem_rw = '0;
    id_use_rs = 0; id_use_rt = 0; id_is_div = 0; id_uses_hilo = 0;
    id_redirect = 0; ex_mem_rd = 0; mem_mem_rd = 0; ext_stall = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1'b1;
    ext_stall = 1'b1;
    id_is_div = 1'b1;
    id_redirect = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (o1[8:4] !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_forced: got %b required 11000", o1[8:4]);
    end
    n_checks++;
    if (db1 !== 1'b0 || cnt1 !== 3'd0 || db2 !== 1'b0 || cnt2 !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b cnt=%0d busy2=%b cnt2=%0d required 0", db1, cnt1, db2, cnt2);
    end
    rst = 1'b0;
    clr_inputs();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_rd = 1; ex_rw = 5'd8; id_rt = 5'd8; id_use_rt = 1; id_rs = 5'd3; id_use_rs = 1;
    @(negedge clk);
    n_checks++;
    if ({pc_wr1, ifid_wr1, bub1} !== 3'b001 || {pc_wr2, bub2} !== 2'b01) begin
      n_fail++;
      $display("FAIL load_use_ex: got lat1=%b%b%b lat2=%b%b required 001/01", pc_wr1, ifid_wr1, bub1, pc_wr2, bub2);
    end
    tick();
    ex_mem_rd = 0; ex_rw = 5'd0; mem_mem_rd = 1; mem_rw = 5'd8;
    @(negedge clk);
    n_checks++;
    if (pc_wr1 !== 1'b1 || bub1 !== 1'b0 || cnt1 !== 3'd1) begin
      n_fail++;
      $display("FAIL load_use_lat1_release: got pc_wr=%b bub=%b cnt=%0d required 1 0 1", pc_wr1, bub1, cnt1);
    end
    n_checks++;
    if (pc_wr2 !== 1'b0 || bub2 !== 1'b1) begin
      n_fail++;
      $display("FAIL load_use_lat2_mem: got pc_wr=%b bub=%b required 0 1", pc_wr2, bub2);
    end
    tick();
    mem_mem_rd = 0; mem_rw = 5'd0;
    @(negedge clk);
    n_checks++;
    if (pc_wr2 !== 1'b1 || cnt2 !== 3'd2 || cnt1 !== 3'd1) begin
      n_fail++;
      $display("FAIL load_use_counts: got pc_wr2=%b cnt2=%0d cnt1=%0d required 1 2 1", pc_wr2, cnt2, cnt1);
    end
    clr_inputs();
  endtask

  task automatic test_zero_and_flags();
    ex_mem_rd = 1; ex_rw = 5'd0; id_rs = 5'd0; id_use_rs = 1;
    mem_mem_rd = 1; mem_rw = 5'd0;
    @(negedge clk);
    n_checks++;
    if (pc_wr1 !== 1'b1 || pc_wr2 !== 1'b1) begin
      n_fail++;
      $display("FAIL reg0_no_hazard: got pc_wr=%b/%b required 1/1", pc_wr1, pc_wr2);
    end
    tick();
    ex_rw = 5'd8; id_rt = 5'd8; id_use_rt = 0; id_rs = 5'd9; id_use_rs = 1;
    mem_rw = 5'd8;
    @(negedge clk);
    n_checks++;
    if (pc_wr1 !== 1'b1 || pc_wr2 !== 1'b1) begin
      n_fail++;
      $display("FAIL use_flag_masked: got pc_wr=%b/%b required 1/1", pc_wr1, pc_wr2);
    end
    tick();
    clr_inputs();
  endtask

  task automatic test_divider();
    id_is_div = 1;
    @(negedge clk);
    n_checks++;
    if (ds1 !== 1'b1 || db1 !== 1'b0) begin
      n_fail++;
      $display("FAIL div_issue: got start=%b busy=%b required 1 0", ds1, db1);
    end
    tick();
    id_is_div = 0; id_uses_hilo = 1;
    for (int c = 1; c <= DC; c++) begin
      @(negedge clk);
      n_checks++;
      if (db1 !== 1'b1 || pc_wr1 !== 1'b0 || bub1 !== 1'b1) begin
        n_fail++;
        $display("FAIL div_busy_c%0d: got busy=%b pc_wr=%b bub=%b required 1 0 1", c, db1, pc_wr1, bub1);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (db1 !== 1'b0 || pc_wr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL div_release: got busy=%b pc_wr=%b required 0 1", db1, pc_wr1);
    end
    tick();
    clr_inputs();
  endtask

  task automatic test_reset_abort();
    id_is_div = 1;
    tick();
    id_is_div = 0;
    @(negedge clk);
    n_checks++;
    if (db1 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_c1_busy: got %b required 1", db1);
    end
    tick();
    rst = 1; id_uses_hilo = 1;
    @(negedge clk);
    n_checks++;
    if (db1 !== 1'b1 || pc_wr1 !== 1'b1 || bub1 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_c2: got busy=%b pc_wr=%b bub=%b required 1 1 0", db1, pc_wr1, bub1);
    end
    tick();
    rst = 0;
    @(negedge clk);
    n_checks++;
    if (db1 !== 1'b0 || pc_wr1 !== 1'b1 || db2 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_c3: got busy=%b pc_wr=%b busy2=%b required 0 1 0", db1, pc_wr1, db2);
    end
    tick();
    clr_inputs();
  endtask

  task automatic test_back_to_back();
    id_is_div = 1;
    for (int c = 0; c <= DC + 1; c++) begin
      @(negedge clk);
      n_checks++;
      if (ds1 !== ((c == 0 || c == DC + 1) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL b2b_start_c%0d: got %b required %b", c, ds1, (c == 0 || c == DC + 1));
      end
      tick();
    end
    id_is_div = 0;
    repeat (DC + 1) tick();
  endtask

  task automatic test_div_vs_load();
    ex_mem_rd = 1; ex_rw = 5'd8; id_rs = 5'd8; id_use_rs = 1; id_is_div = 1;
    @(negedge clk);
    n_checks++;
    if (ds1 !== 1'b0 || bub1 !== 1'b1) begin
      n_fail++;
      $display("FAIL div_vs_load: got start=%b bub=%b required 0 1", ds1, bub1);
    end
    tick();
    clr_inputs();
    @(negedge clk);
    n_checks++;
    if (db1 !== 1'b0) begin
      n_fail++;
      $display("FAIL div_vs_load_idle: got busy=%b required 0", db1);
    end
  endtask

  task automatic test_redirect();
    id_redirect = 1;
    @(negedge clk);
    n_checks++;
    if (fl1 !== 1'b1 || pc_wr1 !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_flush: got flush=%b pc_wr=%b required 1 1", fl1, pc_wr1);
    end
    tick();
    ext_stall = 1;
    @(negedge clk);
    n_checks++;
    if (fl1 !== 1'b0 || pc_wr1 !== 1'b0 || fl2 !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_stalled: got flush=%b pc_wr=%b flush2=%b required 0 0 0", fl1, pc_wr1, fl2);
    end
    tick();
    clr_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    ext_stall = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (int'(cnt1) != ((i > CMAX) ? CMAX : i)) begin
        n_fail++;
        $display("FAIL sat_step%0d: got %0d required %0d", i, cnt1, (i > CMAX) ? CMAX : i);
      end
      tick();
    end
    ext_stall = 0;
    @(negedge clk);
    n_checks++;
    if (cnt1 !== 3'd7 || cnt2 !== 3'd7) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d/%0d required 7/7", cnt1, cnt2);
    end
  endtask

  task automatic test_random();
    logic [8:0] e1, e2;
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      id_rs        = AW'($urandom_range(0, 3));
      id_rt        = AW'($urandom_range(0, 3));
      ex_rw        = AW'($urandom_range(0, 3));
      mem_rw       = AW'($urandom_range(0, 3));
      id_use_rs    = 1'($urandom_range(0, 1));
      id_use_rt    = 1'($urandom_range(0, 1));
      ex_mem_rd    = ($urandom_range(0, 2) == 0);
      mem_mem_rd   = ($urandom_range(0, 2) == 0);
      id_is_div    = ($urandom_range(0, 5) == 0);
      id_uses_hilo = ($urandom_range(0, 3) == 0);
      id_redirect  = ($urandom_range(0, 3) == 0);
      ext_stall    = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 63) == 0);
      @(negedge clk);
      e1 = model_out(0);
      e2 = model_out(1);
      n_checks++;
      if (o1 !== e1) begin
        n_fail++;
        $display("FAIL rand_lat1 n=%0d: got %b required %b", n, o1, e1);
      end
      n_checks++;
      if (o2 !== e2) begin
        n_fail++;
        $display("FAIL rand_lat2 n=%0d: got %b required %b", n, o2, e2);
      end
      tick();
    end
    rst = 0;
    clr_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    test_reset();
    test_load_use();
    test_zero_and_flags();
    test_divider();
    test_reset_abort();
    test_back_to_back();
    test_div_vs_load();
    test_redirect();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
